// File: rtl/icache_arbiter.sv
// icache_arbiter: arbitrates demand fetch and next-line prefetch onto a single i-cache read port,
// one transaction in flight, with flush abort/drain and prefetch anti-starvation.
module icache_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            fetch_req_i,
  input  logic [XLEN-1:0] fetch_addr_i,
  output logic            fetch_done_o,
  input  logic            pref_req_i,
  input  logic [XLEN-1:0] pref_addr_i,
  output logic            pref_done_o,
  output logic            cache_req_o,
  output logic [XLEN-1:0] cache_addr_o,
  input  logic            cache_ready_i,
  input  logic            cache_done_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;
  state_e          state_q, state_d;
  logic            req_q;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            owner_q, owner_d;
  logic [3:0]      starve_q, starve_d;
  logic            grant_pref;
  assign cache_req_o  = req_q;
  assign cache_addr_o = addr_q;
  // owner_q: 0 = fetch, 1 = prefetch
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    fetch_done_o = 1'b0;
    pref_done_o  = 1'b0;
    grant_pref   = pref_req_i && (!fetch_req_i || starve_q == 4'(STARVE_MAX));
    case (state_q)
      IDLE: if (!flush_i && (fetch_req_i || pref_req_i)) begin
        state_d  = REQ;
        owner_d  = grant_pref;
        addr_d   = grant_pref ? pref_addr_i : fetch_addr_i;
        starve_d = (grant_pref || !pref_req_i) ? 4'd0 :
                   (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
      end
      REQ: if (cache_ready_i) state_d = flush_i ? DRAIN : WAIT;
           else if (flush_i) state_d = IDLE;
      WAIT: if (cache_done_i) begin
        state_d      = IDLE;
        fetch_done_o = !flush_i && !owner_q;
        pref_done_o  = !flush_i && owner_q;
      end else if (flush_i) state_d = DRAIN;
      default: if (cache_done_i) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      owner_q  <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      req_q    <= state_d == REQ;
      addr_q   <= addr_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_icache_arbiter.sv
// tb_icache_arbiter: directed and randomized transactions against a transaction-level model
// of the arbitration and flush rules.
module tb_icache_arbiter;
  localparam int SMAX = 4;
  logic        clk, rst_n, flush;
  logic        fetch_req, pref_req, fetch_done, pref_done;
  logic [31:0] fetch_addr, pref_addr, cache_addr;
  logic        cache_req, cache_ready, cache_done;
  int checks = 0;
  int errors = 0;
  int starve = 0;
  bit gp;
  bit [9:0] order;

  icache_arbiter #(.XLEN(32), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_done_o(fetch_done),
    .pref_req_i(pref_req), .pref_addr_i(pref_addr), .pref_done_o(pref_done),
    .cache_req_o(cache_req), .cache_addr_o(cache_addr),
    .cache_ready_i(cache_ready), .cache_done_i(cache_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One complete transaction: grant, rw cycles of back-pressure, dw cycles before the response.
  task automatic txn(input bit f, input bit p, input logic [31:0] fa, input logic [31:0] pa,
                     input int rw, input int dw, output bit g);
    logic [31:0] ea;
    g  = p && (!f || starve == SMAX);
    ea = g ? pa : fa;
    starve = (g || !p) ? 0 : (starve + 1 > SMAX ? SMAX : starve + 1);
    fetch_req = f; pref_req = p; fetch_addr = fa; pref_addr = pa;
    step();
    chk("grant_req", cache_req, 1);
    chk("grant_addr", cache_addr, ea);
    for (int i = 0; i < rw; i++) begin
      fetch_addr = $urandom; pref_addr = $urandom;
      step();
      chk("req_hold", cache_req, 1);
      chk("addr_hold", cache_addr, ea);
    end
    cache_ready = 1;
    step();
    cache_ready = 0;
    chk("req_drop", cache_req, 0);
    for (int i = 0; i < dw; i++) begin
      #1 chk("early_done", {fetch_done, pref_done}, 0);
      step();
    end
    cache_done = 1;
    #1 chk("done_pulse", {fetch_done, pref_done}, {!g, g});
    step();
    cache_done = 0;
    if (g) pref_req = 0; else fetch_req = 0;
    #1 chk("done_single", {fetch_done, pref_done}, 0);
  endtask

  // Grant a fetch-only request and leave it accepted (WAIT) or just issued (REQ).
  task automatic grant_fetch(input logic [31:0] a, input bit accept);
    fetch_req = 1; pref_req = 0; fetch_addr = a;
    starve = 0;
    step();
    chk("g_req", cache_req, 1);
    if (accept) begin
      cache_ready = 1;
      step();
      cache_ready = 0;
    end
  endtask

  initial begin
    rst_n = 0; flush = 0; fetch_req = 0; pref_req = 0; fetch_addr = 0; pref_addr = 0;
    cache_ready = 0; cache_done = 0;
    step(); step();
    chk("rst_req", cache_req, 0);
    chk("rst_addr", cache_addr, 0);
    chk("rst_done", {fetch_done, pref_done}, 0);
    rst_n = 1;
    step();
    // single fetch, ready at once, response two cycles after acceptance
    txn(1, 0, 32'h1000, 32'h0, 0, 1, gp);
    // starvation relief with both held
    for (int i = 0; i < 10; i++) begin
      txn(1, 1, 32'h2000, 32'h2040, 0, 0, gp);
      order[i] = gp;
    end
    chk("grant_order", {22'd0, order}, {22'd0, 10'b1000010000});
    // flush in IDLE suppresses the grant and keeps the counter at its limit
    while (starve != SMAX) txn(1, 1, $urandom, $urandom, 0, 0, gp);
    fetch_req = 1; pref_req = 1; flush = 1;
    step();
    flush = 0;
    chk("idle_flush", cache_req, 0);
    txn(1, 1, 32'h4000, 32'h4040, 1, 0, gp);
    chk("idle_flush_pref", {31'd0, gp}, 1);
    // flush in REQ without ready drops the request
    grant_fetch(32'h5000, 0);
    flush = 1; fetch_req = 0;
    #1 chk("reqflush_done", {fetch_done, pref_done}, 0);
    step();
    flush = 0;
    chk("reqflush_drop", cache_req, 0);
    step();
    chk("reqflush_idle", cache_req, 0);
    txn(1, 0, 32'h5100, 0, 0, 0, gp);
    // flush in REQ with ready drains; new request and repeated flush ignored in DRAIN
    grant_fetch(32'h6000, 0);
    flush = 1; cache_ready = 1;
    step();
    flush = 0; cache_ready = 0;
    chk("drain_req", cache_req, 0);
    fetch_req = 1; flush = 1;
    step();
    flush = 0;
    chk("drain_nogrant", cache_req, 0);
    cache_done = 1;
    #1 chk("drain_done", {fetch_done, pref_done}, 0);
    step();
    cache_done = 0;
    chk("drain_exit", cache_req, 0);
    txn(1, 0, 32'h6100, 0, 0, 0, gp);
    // flush in WAIT, response 3 cycles later
    grant_fetch(32'h7000, 1);
    flush = 1; fetch_req = 0;
    step();
    flush = 0;
    step(); step();
    cache_done = 1;
    #1 chk("waitflush_done", {fetch_done, pref_done}, 0);
    step();
    cache_done = 0;
    txn(1, 0, 32'h3000, 0, 0, 0, gp);
    // flush coincident with response
    grant_fetch(32'h8000, 1);
    flush = 1; cache_done = 1; fetch_req = 0;
    #1 chk("coinc_done", {fetch_done, pref_done}, 0);
    step();
    flush = 0; cache_done = 0;
    chk("coinc_idle", cache_req, 0);
    txn(0, 1, 0, 32'h8040, 0, 2, gp);
    // stray response in IDLE is ignored
    cache_done = 1;
    #1 chk("stray_done", {fetch_done, pref_done}, 0);
    step();
    cache_done = 0;
    chk("stray_req", cache_req, 0);
    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      bit f, p;
      f = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      if (!f && !p) f = 1;
      txn(f, p, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), gp);
    end
    // asynchronous reset during WAIT, stale response afterwards
    txn(1, 1, $urandom, $urandom, 0, 0, gp);
    grant_fetch(32'h9000, 1);
    #2 rst_n = 0;
    cache_done = 1;
    #1 chk("arst_req", cache_req, 0);
    chk("arst_addr", cache_addr, 0);
    chk("arst_done", {fetch_done, pref_done}, 0);
    fetch_req = 0; pref_req = 0;
    step();
    rst_n = 1;
    starve = 0;
    #1 chk("stale_done", {fetch_done, pref_done}, 0);
    step();
    cache_done = 0;
    chk("stale_req", cache_req, 0);
    txn(1, 1, 32'hA000, 32'hA040, 0, 0, gp);
    chk("post_rst_fetch", {31'd0, gp}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_arbiter.md
ICACHE_ARBITER -- requirements
Module: icache_arbiter

Interface
REQ-001 Parameter XLEN, default 32, width of request addresses.
REQ-002 Parameter STARVE_MAX, default 4, consecutive fetch grants tolerated while a prefetch is pending; range 1..15.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  pipeline flush; aborts or discards the current transaction.
REQ-006 fetch_req_i  input  1  demand-fetch request level, held until fetch_done_o.
REQ-007 fetch_addr_i  input  XLEN  demand-fetch line address.
REQ-008 fetch_done_o  output  1  one-cycle pulse: demand response valid on cache data bus.
REQ-009 pref_req_i  input  1  next-line prefetch request level, held until pref_done_o.
REQ-010 pref_addr_i  input  XLEN  prefetch line address.
REQ-011 pref_done_o  output  1  one-cycle pulse: prefetch response valid.
REQ-012 cache_req_o  output  1  read request to i-cache, registered.
REQ-013 cache_addr_o  output  XLEN  address of the granted request, registered.
REQ-014 cache_ready_i  input  1  i-cache accepts request this cycle when cache_req_o=1.
REQ-015 cache_done_i  input  1  i-cache response valid, one cycle.

Function
REQ-016 The block SHALL be a 4-state FSM: IDLE, REQ (cache_req_o=1, awaiting cache_ready_i), WAIT (accepted, awaiting cache_done_i), DRAIN (flushed, discarding one response).
REQ-017 At most one transaction SHALL be outstanding; request inputs are sampled only in IDLE.
REQ-018 In IDLE with any request and flush_i=0, the arbiter SHALL grant one requester, latch its address into cache_addr_o and its identity into an owner register, and enter REQ; cache_req_o rises the next cycle (grant latency 1).
REQ-019 Priority: fetch over prefetch, except when the starvation counter equals STARVE_MAX and both request, in which case prefetch SHALL be granted.
REQ-020 Starvation counter SHALL increment (saturating at STARVE_MAX) on each fetch grant while pref_req_i=1, and clear on a prefetch grant or a fetch grant with pref_req_i=0.
REQ-021 REQ: cache_ready_i=1 -> WAIT, cache_req_o deasserts next cycle; cache_addr_o SHALL stay stable while in REQ.
REQ-022 WAIT: cache_done_i=1 -> IDLE, with fetch_done_o or pref_done_o (per owner) asserted combinationally in the same cycle; never both.
REQ-023 A new grant MAY occur in the cycle after return to IDLE (back-to-back throughput: one transaction per 3 cycles minimum with zero-wait cache).
REQ-024 flush_i in IDLE SHALL suppress granting that cycle; counter unchanged.
REQ-025 flush_i in REQ with cache_ready_i=0 SHALL drop the request -> IDLE, cache_req_o=0 next cycle.
REQ-026 flush_i in REQ with cache_ready_i=1 SHALL -> DRAIN (request was accepted).
REQ-027 flush_i in WAIT with cache_done_i=0 -> DRAIN; with cache_done_i=1 -> IDLE and done pulses SHALL be suppressed.
REQ-028 DRAIN: done outputs SHALL stay 0; cache_done_i=1 -> IDLE; flush_i in DRAIN has no further effect.
REQ-029 cache_done_i outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-030 Asynchronous reset SHALL force IDLE, cache_req_o=0, cache_addr_o=0, owner=fetch, starvation counter=0; fetch_done_o=pref_done_o=0.
REQ-031 Reset mid-transaction SHALL abandon it without a done pulse; no drain is performed afterwards.

Verification
REQ-032 fetch_req=1 addr 0x1000, cache ready immediately, done 2 cycles later -> cache_req_o 1 cycle, cache_addr_o=0x1000, single fetch_done_o pulse.
REQ-033 fetch and prefetch held continuously (0x2000/0x2040), STARVE_MAX=4 -> grant order F,F,F,F,P,F,F,F,F,P.
REQ-034 flush in REQ with cache_ready_i=0 -> cache_req_o low next cycle, no done pulse, next grant resumes from IDLE.
REQ-035 flush in WAIT, done arrives 3 cycles later -> DRAIN, no done pulse, IDLE after done; new fetch 0x3000 then served normally.
REQ-036 flush coincident with cache_done_i in WAIT -> IDLE, fetch_done_o=0.
REQ-037 rst_n_i low during WAIT -> all outputs 0 immediately, stale cache_done_i after reset ignored.
